uart_tx_mmio: RTL and testbench

Memory-mapped UART transmitter on the CPU data bus. It sits directly downstream of the processor's data-bus port, in parallel with the data-memory interface. It decodes its own address window and buffers bytes written by the program in a small FIFO. It serialises them 8N1 on `oTX`, with a software-programmable bit period derived from the CPU clock.

---
 rtl/uart_pkg.sv | 36 +++
 rtl/uart_fifo.sv | 68 ++++++
 rtl/uart_tx_mmio.sv | 222 ++++++++++++++++++++++
 tb/tb_uart_tx_mmio.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the memory-mapped UART transmitter: register offsets,
// STATUS bit positions, transmit FSM states and a divisor helper.
package uart_pkg;

    // Register offsets relative to BASE_ADDR
    localparam logic [63:0] UART_TXDATA    = 64'h0000_0000_0000_0000;
    localparam logic [63:0] UART_STATUS    = 64'h0000_0000_0000_0008;
    localparam logic [63:0] UART_DIV       = 64'h0000_0000_0000_0010;
    localparam logic [63:0] UART_WIN_BYTES = 64'd24;

    // STATUS bit positions
    localparam int ST_BUSY    = 0;
    localparam int ST_FULL    = 1;
    localparam int ST_EMPTY   = 2;
    localparam int ST_OVF     = 3;
    localparam int ST_CNT_LSB = 4;

    typedef enum logic [1:0] {
        UART_IDLE  = 2'd0,
        UART_START = 2'd1,
        UART_DATA  = 2'd2,
        UART_STOP  = 2'd3
    } uart_state_t;

    // A programmed divisor of zero behaves as one cycle per bit
    function automatic logic [15:0] uart_div_eff(input logic [15:0] div);
        logic [15:0] eff;
        if (div == 16'd0) begin
            eff = 16'd1;
        end else begin
            eff = div;
        end
        return eff;
    endfunction

endpackage

// File: rtl/uart_fifo.sv
// Synchronous byte FIFO. Pointers carry one extra wrap bit so that equal
// indices can be told apart as full (wrap bits differ) or empty (equal).
// A push on a full FIFO is accepted only when a pop frees a slot that cycle.
module uart_fifo #(
    parameter  int DEPTH = 8,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic          pop,
    input  logic [7:0]    din,
    output logic [7:0]    dout,
    output logic          full,
    output logic          empty,
    output logic [CW-1:0] count
);

    logic [AW:0] wr_ptr_q, wr_ptr_d;
    logic [AW:0] rd_ptr_q, rd_ptr_d;
    logic [7:0]  mem_q [DEPTH];
    logic        push_ok_s, pop_ok_s;

    // Occupancy flags and head-of-queue data from the pointer pair
    always_comb begin
        empty = (wr_ptr_q == rd_ptr_q);
        full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
        count = wr_ptr_q - rd_ptr_q;
        dout  = mem_q[rd_ptr_q[AW-1:0]];
    end

    // Accepted push/pop and next pointer values
    always_comb begin
        pop_ok_s  = pop && !empty;
        push_ok_s = push && (!full || pop_ok_s);
        if (push_ok_s) begin
            wr_ptr_d = wr_ptr_q + (AW+1)'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_ok_s) begin
            rd_ptr_d = rd_ptr_q + (AW+1)'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
    end

    // Storage write; contents need no reset because the pointers define validity
    always_ff @(posedge clk) begin
        if (push_ok_s) begin
            mem_q[wr_ptr_q[AW-1:0]] <= din;
        end
    end

    // Pointer registers; reset flushes the FIFO
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= {(AW+1){1'b0}};
            rd_ptr_q <= {(AW+1){1'b0}};
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

endmodule

// File: rtl/uart_tx_mmio.sv
// Memory-mapped 8N1 UART transmitter on the CPU data bus: window decode,
// STATUS/DIVISOR registers, TX FIFO and the bit-timing state machine.
module uart_tx_mmio
    import uart_pkg::*;
#(
    parameter logic [63:0] BASE_ADDR     = 64'h0000_0000_0010_0100,
    parameter logic [15:0] CLK_DIV_RESET = 16'd434,
    parameter int          FIFO_DEPTH    = 8
) (
    input  logic        iCLK,
    input  logic        iRST,
    input  logic        wReadEnable,
    input  logic        wWriteEnable,
    input  logic [3:0]  wByteEnable,
    input  logic [63:0] wAddress,
    input  logic [63:0] wWriteData,
    output logic [63:0] wReadData,
    output logic        oHit,
    output logic        oTX
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic [63:0]   offset_s;
    logic          hit_s, wr_s;
    logic          push_s, pop_s, st_clr_s, ovf_set_s;
    logic          div_wr_lo_s, div_wr_hi_s;
    logic          fifo_full_s, fifo_empty_s;
    logic [7:0]    fifo_dout_s;
    logic [CW-1:0] fifo_count_s;
    logic [31:0]   count_wide_s;
    logic [7:0]    status_s;
    logic [63:0]   rdata_s;
    logic [15:0]   div_eff_s;
    logic          unused_s;

    uart_state_t   state_q, state_d;
    logic [15:0]   cnt_q, cnt_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shift_q, shift_d;
    logic          tx_q, tx_d;
    logic [15:0]   div_q, div_d;
    logic          ovf_q, ovf_d;

    uart_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (iCLK),
        .rst   (iRST),
        .push  (push_s),
        .pop   (pop_s),
        .din   (wWriteData[7:0]),
        .dout  (fifo_dout_s),
        .full  (fifo_full_s),
        .empty (fifo_empty_s),
        .count (fifo_count_s)
    );

    // Address window decode and per-register write strobes
    always_comb begin
        offset_s    = wAddress - BASE_ADDR;
        hit_s       = (wReadEnable || wWriteEnable) &&
                      (wAddress >= BASE_ADDR) && (offset_s < UART_WIN_BYTES);
        wr_s        = wWriteEnable && hit_s;
        push_s      = wr_s && (offset_s == UART_TXDATA) && wByteEnable[0];
        st_clr_s    = wr_s && (offset_s == UART_STATUS) && wByteEnable[0] &&
                      wWriteData[ST_OVF];
        div_wr_lo_s = wr_s && (offset_s == UART_DIV) && wByteEnable[0];
        div_wr_hi_s = wr_s && (offset_s == UART_DIV) && wByteEnable[1];
    end

    // STATUS image built from pre-edge FIFO and FSM state
    always_comb begin
        count_wide_s                = 32'(fifo_count_s);
        status_s                    = 8'd0;
        status_s[ST_BUSY]           = (state_q != UART_IDLE) || !fifo_empty_s;
        status_s[ST_FULL]           = fifo_full_s;
        status_s[ST_EMPTY]          = fifo_empty_s;
        status_s[ST_OVF]            = ovf_q;
        status_s[ST_CNT_LSB +: 4]   = count_wide_s[3:0];
    end

    // Read mux; anything unselected or unmapped reads as zero
    always_comb begin
        rdata_s = 64'd0;
        if (hit_s) begin
            case (offset_s)
                UART_STATUS: rdata_s = {56'd0, status_s};
                UART_DIV:    rdata_s = {48'd0, div_q};
                default:     rdata_s = 64'd0;
            endcase
        end else begin
            rdata_s = 64'd0;
        end
    end

    // DIVISOR byte-lane updates and sticky overflow (a new overflow wins over a clear)
    always_comb begin
        ovf_set_s = push_s && fifo_full_s && !pop_s;
        div_d     = div_q;
        if (div_wr_lo_s) begin
            div_d[7:0] = wWriteData[7:0];
        end else begin
            div_d[7:0] = div_q[7:0];
        end
        if (div_wr_hi_s) begin
            div_d[15:8] = wWriteData[15:8];
        end else begin
            div_d[15:8] = div_q[15:8];
        end
        if (ovf_set_s) begin
            ovf_d = 1'b1;
        end else if (st_clr_s) begin
            ovf_d = 1'b0;
        end else begin
            ovf_d = ovf_q;
        end
    end

    // Transmit FSM next state: each bit lasts DIVISOR cycles, the counter is
    // reloaded at every bit boundary so a new DIVISOR applies from the next bit
    always_comb begin
        div_eff_s = uart_div_eff(div_q);
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_d     = bit_q;
        shift_d   = shift_q;
        tx_d      = tx_q;
        pop_s     = 1'b0;
        case (state_q)
            UART_IDLE: begin
                if (!fifo_empty_s) begin
                    pop_s   = 1'b1;
                    shift_d = fifo_dout_s;
                    cnt_d   = div_eff_s;
                    tx_d    = 1'b0;
                    state_d = UART_START;
                end else begin
                    tx_d    = 1'b1;
                    cnt_d   = 16'd0;
                end
            end
            UART_START: begin
                if (cnt_q <= 16'd1) begin
                    tx_d    = shift_q[0];
                    shift_d = {1'b0, shift_q[7:1]};
                    bit_d   = 3'd0;
                    cnt_d   = div_eff_s;
                    state_d = UART_DATA;
                end else begin
                    cnt_d   = cnt_q - 16'd1;
                end
            end
            UART_DATA: begin
                if (cnt_q <= 16'd1) begin
                    cnt_d = div_eff_s;
                    if (bit_q == 3'd7) begin
                        tx_d    = 1'b1;
                        state_d = UART_STOP;
                    end else begin
                        tx_d    = shift_q[0];
                        shift_d = {1'b0, shift_q[7:1]};
                        bit_d   = bit_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            UART_STOP: begin
                if (cnt_q <= 16'd1) begin
                    if (!fifo_empty_s) begin
                        pop_s   = 1'b1;
                        shift_d = fifo_dout_s;
                        cnt_d   = div_eff_s;
                        tx_d    = 1'b0;
                        state_d = UART_START;
                    end else begin
                        tx_d    = 1'b1;
                        cnt_d   = 16'd0;
                        state_d = UART_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            default: begin
                tx_d    = 1'b1;
                cnt_d   = 16'd0;
                state_d = UART_IDLE;
            end
        endcase
    end

    // FSM, shift register, line driver and register-file flops
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            state_q <= UART_IDLE;
            cnt_q   <= 16'd0;
            bit_q   <= 3'd0;
            shift_q <= 8'd0;
            tx_q    <= 1'b1;
            div_q   <= CLK_DIV_RESET;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
            div_q   <= div_d;
            ovf_q   <= ovf_d;
        end
    end

    assign wReadData = rdata_s;
    assign oHit      = hit_s;
    assign oTX       = tx_q;

    // Upper data lanes and wide count bits have no register behind them
    assign unused_s = ^{wWriteData[63:16], wByteEnable[3:2], count_wide_s[31:4]};

endmodule

// File: tb/tb_uart_tx_mmio.sv
// Scoreboard bench for uart_tx_mmio: a queue-based reference model predicts
// accepted bytes and STATUS, a line monitor decodes frames from oTX and
// compares them against the expected-byte queue.
`timescale 1ns/1ps
module tb_uart_tx_mmio;

    localparam logic [63:0] BASE  = 64'h0000_0000_0010_0100;
    localparam int          DEPTH = 8;

    logic        clk = 1'b0;
    logic        rst, re, we;
    logic [3:0]  be;
    logic [63:0] addr, wdata, rdata;
    logic        hit, tx;

    always #5 clk = ~clk;

    uart_tx_mmio #(
        .BASE_ADDR     (BASE),
        .CLK_DIV_RESET (16'd434),
        .FIFO_DEPTH    (DEPTH)
    ) dut (
        .iCLK         (clk),
        .iRST         (rst),
        .wReadEnable  (re),
        .wWriteEnable (we),
        .wByteEnable  (be),
        .wAddress     (addr),
        .wWriteData   (wdata),
        .wReadData    (rdata),
        .oHit         (hit),
        .oTX          (tx)
    );

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- reference model ----------------
    byte unsigned m_wait[$];   // bytes waiting in the FIFO
    byte unsigned exp_q[$];    // scoreboard: bytes expected on the line, in order
    bit           m_active = 1'b0;
    bit           m_ovf    = 1'b0;
    int           m_end    = 0;
    int           m_fdiv   = 1;
    logic [15:0]  m_div    = 16'd434;
    int           medge    = 0;

    function automatic logic [7:0] m_status();
        int n;
        n = m_wait.size();
        return {4'(n), m_ovf, (n == 0), (n == DEPTH), (m_active || n > 0)};
    endfunction

    initial forever begin : ref_model
        bit pop, acc, rej;
        int deff;
        @(posedge clk);
        medge++;
        if (rst) begin
            m_wait.delete();
            exp_q.delete();
            m_active = 1'b0;
            m_ovf    = 1'b0;
            m_div    = 16'd434;
        end else begin
            pop = 1'b0; acc = 1'b0; rej = 1'b0;
            deff = (m_div == 16'd0) ? 1 : int'(m_div);
            if (m_active && medge == m_end) m_active = 1'b0;
            if (!m_active && m_wait.size() > 0) pop = 1'b1;
            if (we && addr == BASE && be[0]) begin
                if (m_wait.size() < DEPTH || pop) acc = 1'b1;
                else rej = 1'b1;
            end
            if (pop) begin
                void'(m_wait.pop_front());
                m_active = 1'b1;
                m_end    = medge + 10 * deff;
                m_fdiv   = deff;
            end
            if (acc) begin
                m_wait.push_back(wdata[7:0]);
                exp_q.push_back(wdata[7:0]);
            end
            if (we && addr == BASE + 64'h10) begin
                if (be[0]) m_div[7:0]  = wdata[7:0];
                if (be[1]) m_div[15:8] = wdata[15:8];
            end
            if (we && addr == BASE + 64'h8 && be[0] && wdata[3]) m_ovf = 1'b0;
            if (rej) m_ovf = 1'b1;
        end
    end

    // ---------------- line monitor ----------------
    bit mon_in = 1'b0;
    int mon_div = 1;
    bit mon_s[$];
    int starts[$];
    int frames = 0;

    initial forever begin : line_monitor
        bit ok;
        byte unsigned b, e;
        @(negedge clk);
        if (rst) begin
            mon_in = 1'b0;
            mon_s.delete();
        end else if (!mon_in) begin
            if (tx == 1'b0) begin
                mon_in  = 1'b1;
                mon_div = m_fdiv;
                starts.push_back(cyc);
                mon_s.delete();
                mon_s.push_back(tx);
            end
        end else begin
            mon_s.push_back(tx);
        end
        if (mon_in && mon_s.size() == 10 * mon_div) begin
            ok = 1'b1;
            b  = 8'd0;
            for (int k = 0; k < 10; k++)
                for (int j = 0; j < mon_div; j++)
                    if (mon_s[k*mon_div + j] != mon_s[k*mon_div]) ok = 1'b0;
            if (mon_s[0] != 1'b0 || mon_s[9*mon_div] != 1'b1) ok = 1'b0;
            for (int k = 0; k < 8; k++) b[k] = mon_s[(k+1)*mon_div];
            checks++;
            if (!ok) begin
                errors++;
                $display("FAIL frame_shape at cycle %0d: bad start/stop or bit length (div=%0d)", cyc, mon_div);
            end
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL frame_unexpected got=%02h expected no frame", b);
            end else begin
                e = exp_q.pop_front();
                if (b != e) begin
                    errors++;
                    $display("FAIL frame_data got=%02h expected=%02h", b, e);
                end
            end
            frames++;
            mon_in = 1'b0;
        end
    end

    // ---------------- helpers ----------------
    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_write(input logic [63:0] off, input logic [63:0] d, input logic [3:0] b);
        we = 1'b1; addr = BASE + off; wdata = d; be = b;
        @(posedge clk);
        #1;
        we = 1'b0; addr = 64'd0; wdata = 64'd0; be = 4'd0;
    endtask

    task automatic rd_chk(input string name, input logic [63:0] off, input logic [63:0] exp);
        re = 1'b1; addr = BASE + off;
        #1;
        chk(name, rdata, exp);
        re = 1'b0; addr = 64'd0;
    endtask

    task automatic st_model(input string name);
        rd_chk(name, 64'h8, {56'd0, m_status()});
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int c0, f0, s0, s1, t;
        rst = 1'b1; re = 1'b0; we = 1'b0; be = 4'd0; addr = 64'd0; wdata = 64'd0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // reset state
        chk("reset_tx", {63'd0, tx}, 64'd1);
        rd_chk("reset_status", 64'h8, 64'h04);
        rd_chk("reset_div", 64'h10, 64'd434);

        // single frame, DIVISOR=4
        bus_write(64'h10, 64'd4, 4'b0011);
        rd_chk("div4", 64'h10, 64'd4);
        starts.delete();
        f0 = frames;
        bus_write(64'h0, 64'h55, 4'b0001);
        c0 = cyc;
        rd_chk("status_after_e0", 64'h8, 64'h11);
        for (int i = 0; i < 45; i++) begin
            tick();
            st_model("status_frame1");
            if (cyc == c0 + 40) rd_chk("busy_last_stop", 64'h8, 64'h05);
            if (cyc == c0 + 41) rd_chk("busy_dropped", 64'h8, 64'h04);
        end
        s0 = (starts.size() > 0) ? starts[0] : -1;
        chk("frame1_latency", 64'(s0), 64'(c0 + 1));
        chk("frame1_count", 64'(frames), 64'(f0 + 1));

        // back-to-back frames, DIVISOR=2
        bus_write(64'h10, 64'd2, 4'b0001);
        starts.delete();
        f0 = frames;
        bus_write(64'h0, 64'h41, 4'b0001);
        c0 = cyc;
        bus_write(64'h0, 64'hC3, 4'b0001);
        for (int i = 0; i < 50; i++) begin
            tick();
            st_model("status_b2b");
        end
        s0 = (starts.size() > 0) ? starts[0] : -1;
        s1 = (starts.size() > 1) ? starts[1] : -1;
        chk("b2b_first_start", 64'(s0), 64'(c0 + 1));
        chk("b2b_no_gap", 64'(s1), 64'(c0 + 21));
        chk("b2b_frames", 64'(frames), 64'(f0 + 2));

        // overflow with a slow line
        bus_write(64'h10, 64'd1000, 4'b0011);
        rd_chk("div1000", 64'h10, 64'd1000);
        for (int i = 0; i < 10; i++) bus_write(64'h0, 64'($urandom_range(0, 255)), 4'b0001);
        st_model("status_overflow_model");
        rd_chk("status_overflow", 64'h8, 64'h8B);
        bus_write(64'h8, 64'hF7, 4'b0001);
        rd_chk("status_no_clear", 64'h8, 64'h8B);
        bus_write(64'h8, 64'h08, 4'b0001);
        rd_chk("status_ovf_cleared", 64'h8, 64'h83);
        st_model("status_cleared_model");
        rst = 1'b1; tick(); rst = 1'b0;
        rd_chk("status_flushed", 64'h8, 64'h04);

        // reset during DATA bit 3
        bus_write(64'h10, 64'd4, 4'b0011);
        f0 = frames;
        bus_write(64'h0, 64'hA5, 4'b0001);
        c0 = cyc;
        bus_write(64'h0, 64'h3C, 4'b0001);
        while (cyc < c0 + 18) tick();
        chk("tx_in_bit3", {63'd0, tx}, 64'd0);
        rst = 1'b1; tick(); rst = 1'b0;
        chk("tx_after_reset", {63'd0, tx}, 64'd1);
        rd_chk("status_after_reset", 64'h8, 64'h04);
        rd_chk("div_after_reset", 64'h10, 64'd434);
        repeat (100) tick();
        chk("no_frames_after_reset", 64'(frames), 64'(f0));
        chk("tx_idle_after_reset", {63'd0, tx}, 64'd1);

        // window decode and lane gating
        re = 1'b1; addr = BASE + 64'h18; #1;
        chk("hit_past_window", {63'd0, hit}, 64'd0);
        chk("rdata_past_window", rdata, 64'd0);
        addr = BASE - 64'h8; #1;
        chk("hit_below_window", {63'd0, hit}, 64'd0);
        addr = BASE + 64'h10; #1;
        chk("hit_div", {63'd0, hit}, 64'd1);
        addr = BASE + 64'hC; #1;
        chk("hit_hole", {63'd0, hit}, 64'd1);
        chk("rdata_hole", rdata, 64'd0);
        re = 1'b0; addr = 64'd0; #1;
        chk("hit_no_strobe", {63'd0, hit}, 64'd0);
        rd_chk("txdata_reads_zero", 64'h0, 64'd0);
        bus_write(64'h0, 64'h77, 4'b0010);
        rd_chk("lane1_no_push", 64'h8, 64'h04);

        // randomized bursts at random divisors
        for (int r = 0; r < 6; r++) begin
            bus_write(64'h10, 64'($urandom_range(0, 5)), 4'b0011);
            for (int i = 0; i < int'($urandom_range(1, 12)); i++) begin
                bus_write(64'h0, 64'($urandom_range(0, 255)), 4'b0001);
                st_model("status_rand_burst");
                repeat ($urandom_range(0, 3)) begin
                    tick();
                    st_model("status_rand_gap");
                end
            end
            t = 0;
            while (t < 3000 && (m_status()[0] || mon_in || exp_q.size() > 0)) begin
                tick();
                st_model("status_rand_drain");
                t++;
            end
            chk("rand_drained", 64'(exp_q.size()), 64'd0);
            bus_write(64'h8, 64'h08, 4'b0001);
            st_model("status_rand_end");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // watchdog
    initial begin
        #5ms;
        $display("FAIL watchdog: simulation did not finish (checks=%0d)", checks);
        $fatal(1);
    end

endmodule
